// File: rtl/tk1_mon_if.sv
// Bus bundle between the tk1 monitor and its surroundings: CPU snoop, LED path and MMIO slave port.
interface tk1_mon_if;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic        cpu_instr;
  logic [3:0]  cpu_wstrb;
  logic        force_trap;
  logic [2:0]  led_in;
  logic [2:0]  led_out;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_instr, cpu_wstrb, led_in, cs, we, address, write_data,
    output force_trap, led_out, read_data, ready
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_instr, cpu_wstrb, led_in, cs, we, address, write_data,
    input  force_trap, led_out, read_data, ready
  );
endinterface

// File: rtl/tk1_mon.sv
// tk1 CPU security monitor: lockable deny regions, fixed RAM/FW-RAM execute checks,
// first-violation capture, saturating violation counter and trap-blink LED mux.
module tk1_mon #(
    parameter int unsigned NUM_REGIONS     = 4,
    parameter int unsigned BLINK_CTR_WIDTH = 24,
    parameter int unsigned RAM_ADDR_BITS   = 17,
    parameter logic [31:0] FW_RAM_FIRST    = 32'hd0000000,
    parameter logic [31:0] FW_RAM_LAST     = 32'hd00007ff
) (
    input  logic      clk,
    input  logic      reset,
    tk1_mon_if.slave  bus
);

    localparam logic [31:0] NAME0   = 32'h6d6f6e20;
    localparam logic [31:0] VERSION = 32'h00000001;

    logic [31:0]            r_first [NUM_REGIONS];
    logic [31:0]            r_last  [NUM_REGIONS];
    logic [2:0]             r_deny  [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] r_lock;

    logic                       r_trapped;
    logic [2:0]                 r_cause;
    logic [2:0]                 r_idx;
    logic [31:0]                r_viol_addr;
    logic [15:0]                r_viol_count;
    logic [BLINK_CTR_WIDTH-1:0] r_blink_ctr;
    logic                       r_blink;

    logic [7:0]  w_ridx;
    logic        w_rsel;
    logic        w_wr;
    logic [31:0] w_rdata;

    logic        w_exec;
    logic        w_write;
    logic        w_read;
    logic        w_ram_viol;
    logic        w_fw_viol;
    logic        w_found;
    logic [2:0]  w_hit_idx;
    logic [2:0]  w_cause;
    logic [2:0]  w_idx;
    logic        w_viol;

    // Region registers start at word 0x10, four words per region (fourth word unmapped).
    assign w_ridx = {2'b00, bus.address[7:2]} - 8'd4;
    assign w_rsel = (bus.address >= 8'h10) && (w_ridx < 8'(NUM_REGIONS)) && (bus.address[1:0] != 2'd3);
    assign w_wr   = bus.cs && bus.we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                r_first[i] <= '0;
                r_last[i]  <= '0;
                r_deny[i]  <= '0;
            end
            r_lock <= '0;
        end else if (w_wr && w_rsel) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                if (w_ridx == 8'(i) && !r_lock[i]) begin
                    case (bus.address[1:0])
                        2'd0:    r_first[i] <= bus.write_data;
                        2'd1:    r_last[i]  <= bus.write_data;
                        2'd2: begin
                            r_deny[i] <= bus.write_data[2:0];
                            r_lock[i] <= bus.write_data[31];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_exec     = bus.cpu_instr;
        w_write    = !bus.cpu_instr && (|bus.cpu_wstrb);
        w_read     = !bus.cpu_instr && !(|bus.cpu_wstrb);
        w_ram_viol = (bus.cpu_addr[31:30] == 2'b01) && (|bus.cpu_addr[29:RAM_ADDR_BITS]);
        w_fw_viol  = bus.cpu_instr && (bus.cpu_addr >= FW_RAM_FIRST) && (bus.cpu_addr <= FW_RAM_LAST);
        w_found    = 1'b0;
        w_hit_idx  = '0;
        // Ascending scan with a found flag so the lowest matching region wins.
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (!w_found && r_lock[i] &&
                (r_first[i] <= bus.cpu_addr) && (bus.cpu_addr <= r_last[i]) &&
                ((w_exec && r_deny[i][0]) || (w_write && r_deny[i][1]) || (w_read && r_deny[i][2]))) begin
                w_found   = 1'b1;
                w_hit_idx = 3'(i);
            end
        end
        w_cause = '0;
        w_idx   = '0;
        if (w_ram_viol) begin
            w_cause = 3'd1;
        end else if (w_fw_viol) begin
            w_cause = 3'd2;
        end else if (w_found) begin
            w_cause = w_exec ? 3'd3 : (w_write ? 3'd4 : 3'd5);
            w_idx   = w_hit_idx;
        end
        w_viol = bus.cpu_valid && (w_cause != 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trapped    <= 1'b0;
            r_cause      <= '0;
            r_idx        <= '0;
            r_viol_addr  <= '0;
            r_viol_count <= '0;
        end else if (w_viol) begin
            if (!r_trapped) begin
                r_trapped   <= 1'b1;
                r_cause     <= w_cause;
                r_idx       <= w_idx;
                r_viol_addr <= bus.cpu_addr;
            end
            if (r_viol_count != 16'hffff) begin
                r_viol_count <= r_viol_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_ctr <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_blink_ctr <= r_blink_ctr + 1'b1;
            if (&r_blink_ctr) begin
                r_blink <= ~r_blink;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.cs && !bus.we) begin
            case (bus.address)
                8'h00:   w_rdata = NAME0;
                8'h01:   w_rdata = VERSION;
                8'h02:   w_rdata = {21'b0, r_idx, 4'b0, r_cause, r_trapped};
                8'h03:   w_rdata = r_viol_addr;
                8'h04:   w_rdata = {16'b0, r_viol_count};
                default: begin
                    if (w_rsel) begin
                        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                            if (w_ridx == 8'(i)) begin
                                case (bus.address[1:0])
                                    2'd0:    w_rdata = r_first[i];
                                    2'd1:    w_rdata = r_last[i];
                                    2'd2:    w_rdata = {r_lock[i], 28'b0, r_deny[i]};
                                    default: w_rdata = '0;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.read_data  = w_rdata;
    assign bus.ready      = bus.cs;
    assign bus.force_trap = r_trapped;
    assign bus.led_out    = r_trapped ? {r_blink, 2'b00} : bus.led_in;

endmodule

// File: tb/tb_tk1_mon.sv
// Directed self-checking bench for tk1_mon (4 regions, 4-bit blink counter).
module tb_tk1_mon;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    tk1_mon_if bus ();

    tk1_mon #(
        .NUM_REGIONS    (4),
        .BLINK_CTR_WIDTH(4),
        .RAM_ADDR_BITS  (17),
        .FW_RAM_FIRST   (32'hd0000000),
        .FW_RAM_LAST    (32'hd00007ff)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.cpu_valid  = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_instr  = 1'b0;
        bus.cpu_wstrb  = '0;
        bus.cs         = 1'b0;
        bus.we         = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic mmio_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic mmio_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
        #1 d = bus.read_data;
        bus.cs = 1'b0;
    endtask

    task automatic cpu_acc(input logic [31:0] a, input logic instr, input logic [3:0] strb);
        @(negedge clk);
        bus.cpu_valid = 1'b1; bus.cpu_addr = a; bus.cpu_instr = instr; bus.cpu_wstrb = strb;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        mmio_rd(8'h00, d);
        checks++; if (d !== 32'h6d6f6e20) begin failures++; $display("FAIL name0 got=%h exp=%h", d, 32'h6d6f6e20); end
        mmio_rd(8'h01, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL version got=%h exp=%h", d, 32'h1); end
        mmio_rd(8'h02, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        mmio_rd(8'h04, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", d); end
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%b exp=0", bus.force_trap); end
        checks++; if (bus.led_out !== 3'b110) begin failures++; $display("FAIL reset_led got=%b exp=110", bus.led_out); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        mmio_wr(8'h20, 32'h12345678);
        mmio_rd(8'h20, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL region4_read got=%h exp=0", d); end
        mmio_rd(8'h05, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_05 got=%h exp=0", d); end
        mmio_wr(8'h13, 32'hffffffff);
        mmio_rd(8'h13, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_13 got=%h exp=0", d); end
        @(negedge clk);
        bus.cs = 1'b0; bus.address = 8'h00;
        #1;
        checks++; if (bus.read_data !== 32'h0) begin failures++; $display("FAIL rdata_no_cs got=%h exp=0", bus.read_data); end
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL ready_no_cs got=%b exp=0", bus.ready); end
        bus.cs = 1'b1; bus.we = 1'b1;
        #1;
        checks++; if (bus.read_data !== 32'h0) begin failures++; $display("FAIL rdata_we got=%h exp=0", bus.read_data); end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL ready_cs got=%b exp=1", bus.ready); end
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic test_no_trigger();
        do_reset();
        // Region 2 has deny bits but is unlocked; region 3 is locked with FIRST > LAST.
        mmio_wr(8'h18, 32'h40003000);
        mmio_wr(8'h19, 32'h400030ff);
        mmio_wr(8'h1a, 32'h00000007);
        mmio_wr(8'h1c, 32'h40004100);
        mmio_wr(8'h1d, 32'h40004000);
        mmio_wr(8'h1e, 32'h80000007);
        cpu_acc(32'h40003010, 1'b1, 4'h0);
        cpu_acc(32'h40004080, 1'b1, 4'h0);
        cpu_acc(32'h40004100, 1'b0, 4'h0);
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL no_trigger got=%b exp=0", bus.force_trap); end
    endtask

    task automatic test_region_exec();
        logic [31:0] d;
        do_reset();
        mmio_wr(8'h10, 32'h40001000);
        mmio_wr(8'h11, 32'h400010ff);
        mmio_wr(8'h12, 32'h80000001);
        cpu_acc(32'h40001080, 1'b0, 4'h0);
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL exec_read_ok got=%b exp=0", bus.force_trap); end
        cpu_acc(32'h40001080, 1'b1, 4'h0);
        checks++; if (bus.force_trap !== 1'b1) begin failures++; $display("FAIL exec_trap got=%b exp=1", bus.force_trap); end
        mmio_rd(8'h02, d);
        checks++; if (d !== 32'h7) begin failures++; $display("FAIL exec_status got=%h exp=%h", d, 32'h7); end
        mmio_rd(8'h03, d);
        checks++; if (d !== 32'h40001080) begin failures++; $display("FAIL exec_vaddr got=%h exp=%h", d, 32'h40001080); end
        mmio_rd(8'h04, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL exec_count got=%h exp=1", d); end
        checks++; if (bus.led_out[1:0] !== 2'b00) begin failures++; $display("FAIL trap_led_gb got=%b exp=00", bus.led_out[1:0]); end
    endtask

    task automatic test_lock_write();
        logic [31:0] d;
        do_reset();
        mmio_wr(8'h14, 32'h40002000);
        mmio_wr(8'h15, 32'h400020ff);
        mmio_wr(8'h16, 32'h80000002);
        mmio_wr(8'h14, 32'h00000000);
        mmio_wr(8'h16, 32'h00000000);
        mmio_rd(8'h14, d);
        checks++; if (d !== 32'h40002000) begin failures++; $display("FAIL locked_first got=%h exp=%h", d, 32'h40002000); end
        mmio_rd(8'h16, d);
        checks++; if (d !== 32'h80000002) begin failures++; $display("FAIL locked_ctrl got=%h exp=%h", d, 32'h80000002); end
        cpu_acc(32'h40002010, 1'b0, 4'h0);
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL lock_read_ok got=%b exp=0", bus.force_trap); end
        cpu_acc(32'h40002010, 1'b0, 4'hf);
        mmio_rd(8'h02, d);
        checks++; if (d !== 32'h109) begin failures++; $display("FAIL write_status got=%h exp=%h", d, 32'h109); end
    endtask

    task automatic test_priority_sticky();
        logic [31:0] d;
        do_reset();
        mmio_wr(8'h10, 32'h40000000);
        mmio_wr(8'h11, 32'h400fffff);
        mmio_wr(8'h12, 32'h80000004);
        cpu_acc(32'h40020000, 1'b0, 4'h0);
        mmio_rd(8'h02, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL ram_status got=%h exp=%h", d, 32'h3); end
        cpu_acc(32'hd0000010, 1'b1, 4'h0);
        mmio_rd(8'h02, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL sticky_status got=%h exp=%h", d, 32'h3); end
        mmio_rd(8'h03, d);
        checks++; if (d !== 32'h40020000) begin failures++; $display("FAIL sticky_vaddr got=%h exp=%h", d, 32'h40020000); end
        mmio_rd(8'h04, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL sticky_count got=%h exp=2", d); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        do_reset();
        mmio_wr(8'h10, 32'h40001000);
        mmio_wr(8'h11, 32'h400010ff);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = 8'h12; bus.write_data = 32'h80000001;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h40001004; bus.cpu_instr = 1'b1; bus.cpu_wstrb = 4'h0;
        @(negedge clk);
        bus.cs = 1'b0; bus.we = 1'b0; bus.cpu_valid = 1'b0;
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL prewrite_check got=%b exp=0", bus.force_trap); end
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = 8'h02;
        #1 d = bus.read_data;
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL preedge_status got=%h exp=0", d); end
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        #1 d = bus.read_data;
        bus.cs = 1'b0;
        checks++; if (d !== 32'h7) begin failures++; $display("FAIL postedge_status got=%h exp=%h", d, 32'h7); end
    endtask

    task automatic test_saturate_blink_reset();
        logic [31:0] d;
        logic        prev;
        logic        v;
        bit          seen;
        do_reset();
        mmio_wr(8'h10, 32'h10000000);
        mmio_wr(8'h11, 32'h10000fff);
        mmio_wr(8'h12, 32'h80000001);
        @(negedge clk);
        bus.cpu_valid = 1'b1; bus.cpu_addr = 32'hd0000010; bus.cpu_instr = 1'b1; bus.cpu_wstrb = 4'h0;
        repeat (70000) @(negedge clk);
        bus.cpu_valid = 1'b0;
        mmio_rd(8'h04, d);
        checks++; if (d !== 32'hffff) begin failures++; $display("FAIL saturate got=%h exp=%h", d, 32'hffff); end

        @(negedge clk);
        prev = bus.led_out[2];
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.led_out[2] !== prev) seen = 1'b1;
            prev = bus.led_out[2];
        end
        checks++; if (!seen) begin failures++; $display("FAIL blink_toggle got=none exp=toggle_within_40"); end
        v = bus.led_out[2];
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) begin
                checks++; if (bus.led_out !== {v, 2'b00}) begin failures++; $display("FAIL blink_hold k=%0d got=%b exp=%b", k, bus.led_out, {v, 2'b00}); end
            end else begin
                checks++; if (bus.led_out !== {~v, 2'b00}) begin failures++; $display("FAIL blink_flip got=%b exp=%b", bus.led_out, {~v, 2'b00}); end
            end
        end

        mmio_rd(8'h12, d);
        checks++; if (d !== 32'h80000001) begin failures++; $display("FAIL prereset_lock got=%h exp=%h", d, 32'h80000001); end
        @(negedge clk);
        reset = 1'b1;
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = 8'h12;
        #1;
        checks++; if (bus.force_trap !== 1'b0) begin failures++; $display("FAIL async_reset_trap got=%b exp=0", bus.force_trap); end
        checks++; if (bus.read_data !== 32'h0) begin failures++; $display("FAIL async_reset_lock got=%h exp=0", bus.read_data); end
        checks++; if (bus.led_out !== 3'b110) begin failures++; $display("FAIL async_reset_led got=%b exp=110", bus.led_out); end
        bus.cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.led_in  = 3'b110;
        idle_inputs();
        test_reset();
        test_unmapped();
        test_no_trigger();
        test_region_exec();
        test_lock_write();
        test_priority_sticky();
        test_same_cycle();
        test_saturate_blink_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
